// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the pong game blocks.
//   - referee_state_t : state encoding of the point referee FSM
//   - screen geometry : visible width and default goal columns
//   - POINT_W         : width of the point counters feeding the 7-seg display
package pong_pkg;

  localparam int H_ACTIVE           = 640;
  localparam int BALL_X_W           = 10;
  localparam int DEFAULT_LEFT_GOAL  = 8;
  localparam int DEFAULT_RIGHT_GOAL = 631;
  localparam int POINT_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_WAIT = 2'd1,
    ST_PLAY       = 2'd2,
    ST_GAME_OVER  = 2'd3
  } referee_state_t;

endpackage

// File: rtl/frame_countdown.sv
// frame_countdown: loadable down-counter that only advances on frame ticks.
// Ports:
//   clk_100MHz  in  system clock
//   reset       in  synchronous active-high reset (count cleared to 0)
//   load        in  load load_value this cycle (wins over tick)
//   load_value  in  value to load
//   tick        in  frame tick; decrements a non-zero count
//   done        out high in the tick cycle that takes the count from 1 to 0
module frame_countdown
  import pong_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (tick && (count_reg != '0)) begin
      count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Flag the expiring tick itself so the owner can react on the same edge
  // the count reaches zero.
  assign done = tick && !load && (count_reg == WIDTH'(1));

endmodule

// File: rtl/point_referee.sv
// point_referee: goal detection, scoring and serve sequencing for pong.
// Ports:
//   clk_100MHz    in   system clock
//   reset         in   synchronous active-high reset
//   frame_tick    in   one pulse per video frame, ball_x valid then
//   ball_x        in   ball left-edge column
//   start         in   debounced start/serve button pulse
//   score_A       out  one-cycle pulse, player point
//   score_B       out  one-cycle pulse, AI point
//   scorer_reset  out  one-cycle pulse clearing the display on a new game
//   ball_reset    out  level, hold ball at centre
//   serve_dir     out  0 = serve toward player, 1 = toward AI
//   game_over     out  level, match finished
//   winner        out  0 = player, 1 = AI (valid with game_over)
//   points_A/B    out  point totals
module point_referee
  import pong_pkg::*;
#(
  parameter int LEFT_GOAL    = DEFAULT_LEFT_GOAL,
  parameter int RIGHT_GOAL   = DEFAULT_RIGHT_GOAL,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [BALL_X_W-1:0] ball_x,
  input  logic                start,
  output logic                score_A,
  output logic                score_B,
  output logic                scorer_reset,
  output logic                ball_reset,
  output logic                serve_dir,
  output logic                game_over,
  output logic                winner,
  output logic [POINT_W-1:0]  points_A,
  output logic [POINT_W-1:0]  points_B
);

  localparam int CD_W = $clog2(SERVE_FRAMES + 1);

  // Ordered goals make a simultaneous A/B goal impossible; the win score
  // must fit the single-digit display.
  if (!(LEFT_GOAL < RIGHT_GOAL) || (RIGHT_GOAL >= H_ACTIVE)) begin : g_bad_goals
    $error("point_referee: goal columns must satisfy LEFT_GOAL < RIGHT_GOAL < H_ACTIVE");
  end
  if ((WIN_SCORE < 1) || (WIN_SCORE > 9)) begin : g_bad_win
    $error("point_referee: WIN_SCORE must be in 1..9");
  end
  if (SERVE_FRAMES < 1) begin : g_bad_serve
    $error("point_referee: SERVE_FRAMES must be at least 1");
  end

  referee_state_t     state_reg, state_next;
  logic [POINT_W-1:0] points_a_reg, points_a_next;
  logic [POINT_W-1:0] points_b_reg, points_b_next;
  logic               score_a_reg, score_a_next;
  logic               score_b_reg, score_b_next;
  logic               scorer_reset_reg, scorer_reset_next;
  logic               ball_reset_reg, ball_reset_next;
  logic               serve_dir_reg, serve_dir_next;
  logic               game_over_reg, game_over_next;
  logic               winner_reg, winner_next;

  logic               cd_load;
  logic               cd_done;
  logic [POINT_W-1:0] points_a_inc;
  logic [POINT_W-1:0] points_b_inc;

  assign points_a_inc = points_a_reg + POINT_W'(1);
  assign points_b_inc = points_b_reg + POINT_W'(1);

  frame_countdown #(
    .WIDTH (CD_W)
  ) u_serve_countdown (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .load       (cd_load),
    .load_value (CD_W'(SERVE_FRAMES)),
    .tick       (frame_tick),
    .done       (cd_done)
  );

  always_comb begin
    state_next        = state_reg;
    points_a_next     = points_a_reg;
    points_b_next     = points_b_reg;
    score_a_next      = 1'b0;
    score_b_next      = 1'b0;
    scorer_reset_next = 1'b0;
    serve_dir_next    = serve_dir_reg;
    winner_next       = winner_reg;
    cd_load           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_SERVE_WAIT;
          cd_load        = 1'b1;
          serve_dir_next = 1'b0;
        end
      end

      ST_SERVE_WAIT: begin
        if (cd_done) begin
          state_next = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          if (ball_x <= BALL_X_W'(LEFT_GOAL)) begin
            score_b_next   = 1'b1;
            points_b_next  = points_b_inc;
            serve_dir_next = 1'b0;       // serve toward the player who lost the point
            if (points_b_inc == POINT_W'(WIN_SCORE)) begin
              state_next  = ST_GAME_OVER;
              winner_next = 1'b1;
            end else begin
              state_next = ST_SERVE_WAIT;
              cd_load    = 1'b1;
            end
          end else if (ball_x >= BALL_X_W'(RIGHT_GOAL)) begin
            score_a_next   = 1'b1;
            points_a_next  = points_a_inc;
            serve_dir_next = 1'b1;       // serve toward the AI, which lost the point
            if (points_a_inc == POINT_W'(WIN_SCORE)) begin
              state_next  = ST_GAME_OVER;
              winner_next = 1'b0;
            end else begin
              state_next = ST_SERVE_WAIT;
              cd_load    = 1'b1;
            end
          end
        end
      end

      ST_GAME_OVER: begin
        if (start) begin
          state_next        = ST_SERVE_WAIT;
          cd_load           = 1'b1;
          serve_dir_next    = 1'b0;
          scorer_reset_next = 1'b1;
          points_a_next     = '0;
          points_b_next     = '0;
          winner_next       = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Level outputs follow the state being entered so they are registered
    // alongside it.
    ball_reset_next = (state_next != ST_PLAY);
    game_over_next  = (state_next == ST_GAME_OVER);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      points_a_reg     <= '0;
      points_b_reg     <= '0;
      score_a_reg      <= 1'b0;
      score_b_reg      <= 1'b0;
      scorer_reset_reg <= 1'b0;
      ball_reset_reg   <= 1'b1;
      serve_dir_reg    <= 1'b0;
      game_over_reg    <= 1'b0;
      winner_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      points_a_reg     <= points_a_next;
      points_b_reg     <= points_b_next;
      score_a_reg      <= score_a_next;
      score_b_reg      <= score_b_next;
      scorer_reset_reg <= scorer_reset_next;
      ball_reset_reg   <= ball_reset_next;
      serve_dir_reg    <= serve_dir_next;
      game_over_reg    <= game_over_next;
      winner_reg       <= winner_next;
    end
  end

  assign score_A      = score_a_reg;
  assign score_B      = score_b_reg;
  assign scorer_reset = scorer_reset_reg;
  assign ball_reset   = ball_reset_reg;
  assign serve_dir    = serve_dir_reg;
  assign game_over    = game_over_reg;
  assign winner       = winner_reg;
  assign points_A     = points_a_reg;
  assign points_B     = points_b_reg;

endmodule
